// File: rtl/rca_seq_mult.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// One shared ripple-carry adder performs one partial-product addition per
// clock; a three-state sequencer (IDLE/RUN/DONE) loads operands, runs eight
// add-and-shift steps and presents the 16-bit product under valid/ready.

// 8-bit ripple-carry adder: s carries the full sum including the carry-out
// in its top bit; cout duplicates that carry for callers that want it apart.
module rca #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH:0]   s,
    output logic             cout
);

    logic [WIDTH:0] carry;

    // Bit-serial carry chain from LSB to MSB.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
        end
        s[WIDTH] = carry[WIDTH];
        cout     = carry[WIDTH];
    end

endmodule

module rca_seq_mult #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    // The adder and the iteration counter are sized for exactly 8 bits.
    if (WIDTH != 8 || CNT_W != 3) begin : g_param_check
        $error("rca_seq_mult supports only WIDTH=8, CNT_W=3");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // M: multiplicand
    logic [WIDTH-1:0]   acc_q,   acc_d;     // A: upper accumulator
    logic [WIDTH-1:0]   mplr_q,  mplr_d;    // Q: multiplier / low product
    logic               carry_q, carry_d;   // C
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic               accept;

    assign addend = mplr_q[0] ? mcand_q : '0;
    assign accept = in_valid && in_ready;
    assign p      = {acc_q, mplr_q};

    rca #(.WIDTH(WIDTH)) u_rca (
        .x    (acc_q),
        .y    (addend),
        .cin  (carry_q),
        .s    (sum),
        .cout ()
    );

    // State register; reset returns to IDLE and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath next values: load in IDLE, add-and-shift in RUN, hold otherwise.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mcand_d = a;
                    mplr_d  = b;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // {C,A,Q} <= {0, sum, Q[7:1]}: the add and the right shift
                // happen in one step, so C is always cleared afterwards.
                acc_d   = sum[WIDTH:1];
                mplr_d  = {sum[0], mplr_q[WIDTH-1:1]};
                carry_d = 1'b0;
                cnt_d   = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rca_seq_mult.sv
// Self-checking bench for rca_seq_mult: a scoreboard queue of expected
// products, an output monitor, and a transaction-level protocol model.
module tb_rca_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] p;
    logic        busy;

    rca_seq_mult #(.WIDTH(8), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned n_prods  = 0;
    logic [15:0] sb_q[$];

    // Protocol model: one operation in flight, result visible 9 cycles
    // after the cycle in which the operands were accepted.
    logic        m_busy = 1'b0;
    int unsigned m_acc  = 0;
    logic [15:0] m_prod = '0;

    logic fixed_rdy = 1'b1;
    logic rand_rdy  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Consumer readiness: fixed level or random per cycle.
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end

    // Input side of the scoreboard: record a*b for every accepted pair.
    always @(negedge clk) begin
        if (rst) sb_q.delete();
        else if (in_valid && in_ready) sb_q.push_back(16'(a) * 16'(b));
    end

    // Output monitor: every output handshake must match the oldest expected product.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_output: got p=0x%0h expected no output (cycle %0d)", p, cyc);
            end else begin
                check("product", {16'h0, p}, {16'h0, sb_q.pop_front()});
                n_prods++;
            end
        end
    end

    // Protocol model: status outputs, latency and held product every cycle.
    always @(negedge clk) begin
        logic exp_ov;
        exp_ov = m_busy && (cyc - m_acc >= 9);
        check("in_ready", {31'h0, in_ready}, {31'h0, !m_busy && !rst});
        check("busy", {31'h0, busy}, {31'h0, m_busy});
        check("out_valid", {31'h0, out_valid}, {31'h0, exp_ov});
        if (exp_ov) check("p_while_valid", {16'h0, p}, {16'h0, m_prod});
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy && in_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_prod = 16'(a) * 16'(b);
        end else if (exp_ov && out_ready) begin
            m_busy = 1'b0;
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        int unsigned n;
        n = 0;
        @(posedge clk); #1;
        a = x; b = y; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: in_ready never rose for a=%0d b=%0d", x, y);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!m_busy && sb_q.size() == 0) break;
            n++;
            if (n > 300) begin
                n_checks++; n_fail++;
                $display("FAIL idle_timeout: operation not completed, pending=%0d", sb_q.size());
                break;
            end
        end
    endtask

    task automatic wait_out_valid();
        int unsigned n;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 50) begin
                n_checks++; n_fail++;
                $display("FAIL valid_timeout: out_valid got 0 expected 1");
                break;
            end
        end
    endtask

    logic [7:0] dir_a [6] = '{8'd13, 8'd255, 8'd0,   8'd200, 8'd1,   8'd128};
    logic [7:0] dir_b [6] = '{8'd11, 8'd255, 8'd200, 8'd0,   8'd255, 8'd2};

    function automatic logic [7:0] pick();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_p", {16'h0, p}, 32'h0);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed operands, consumer always ready.
        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i]);
            wait_idle();
        end

        // Back-pressure: product must hold while out_ready is low.
        fixed_rdy = 1'b0;
        issue(8'd7, 8'd9);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            check("hold_p", {16'h0, p}, 32'd63);
            check("hold_out_valid", {31'h0, out_valid}, 32'h1);
            check("hold_in_ready", {31'h0, in_ready}, 32'h0);
            @(negedge clk);
        end
        fixed_rdy = 1'b1;
        wait_idle();

        // in_valid held high through RUN with new operands.
        @(posedge clk); #1;
        a = 8'd3; b = 8'd5; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        a = 8'd99; b = 8'd99;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        check("held_pair_count", n_prods, 32'd9);

        // Reset mid-RUN at cnt==4, with a simultaneous in_valid that must be ignored.
        issue(8'd50, 8'd60);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("abort_p", {16'h0, p}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        repeat (15) @(negedge clk);
        issue(8'd6, 8'd7);
        wait_idle();
        check("abort_count", n_prods, 32'd10);

        // Random regression with random consumer stalls and issue gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(pick(), pick());
        end
        rand_rdy = 1'b0;
        wait_idle();
        check("total_products", n_prods, 32'd1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
